branch_cmp_ctrl: RTL and testbench

//  ID-stage controller for the early-branch equality comparator (BEQ/BNE).

---
 rtl/branch_cmp_ctrl_if.sv | 48 ++++
 rtl/branch_cmp_ctrl.sv | 144 ++++++++++++++
 tb/tb_branch_cmp_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/branch_cmp_ctrl_if.sv
// Bundles the ID-stage branch, hazard-source, forwarding and statistics signals
// shared between the pipeline (master) and the branch compare controller (slave).
interface branch_cmp_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             id_branch;
  logic             id_bne;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic [WIDTH-1:0] rf_rs;
  logic [WIDTH-1:0] rf_rt;
  logic             ex_regwrite;
  logic             ex_memread;
  logic [4:0]       ex_rd;
  logic             mem_regwrite;
  logic             mem_memread;
  logic [4:0]       mem_rd;
  logic [WIDTH-1:0] mem_alu;
  logic             wb_regwrite;
  logic [4:0]       wb_rd;
  logic [WIDTH-1:0] wb_data;
  logic [WIDTH-1:0] cmp_a;
  logic [WIDTH-1:0] cmp_b;
  logic             cmp_eq;
  logic             stall;
  logic             branch_taken;
  logic             flush_ifid;
  logic             cnt_clr;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] taken_cnt;

  modport master (
    output id_branch, id_bne, id_rs, id_rt, rf_rs, rf_rt,
           ex_regwrite, ex_memread, ex_rd,
           mem_regwrite, mem_memread, mem_rd, mem_alu,
           wb_regwrite, wb_rd, wb_data, cmp_eq, cnt_clr,
    input  cmp_a, cmp_b, stall, branch_taken, flush_ifid, branch_cnt, taken_cnt
  );

  modport slave (
    input  id_branch, id_bne, id_rs, id_rt, rf_rs, rf_rt,
           ex_regwrite, ex_memread, ex_rd,
           mem_regwrite, mem_memread, mem_rd, mem_alu,
           wb_regwrite, wb_rd, wb_data, cmp_eq, cnt_clr,
    output cmp_a, cmp_b, stall, branch_taken, flush_ifid, branch_cnt, taken_cnt
  );
endinterface

// File: rtl/branch_cmp_ctrl.sv
// ID-stage early-branch controller: RAW hazard stalls, operand forwarding onto
// the equality comparator, same-cycle resolution and saturating branch statistics.
module branch_cmp_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input logic              clk,
  input logic              reset,
  branch_cmp_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STALL   = 2'd1,
    RESOLVE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
  logic             stall_s;
  logic             resolve_s;
  logic             taken_s;
  logic             ex_hit_s;
  logic             mem_hit_s;
  logic             need_two_s;
  logic             need_one_s;

  // Register 0 is hard-wired, so it never creates a dependency.
  function automatic logic hit(input logic [4:0] x, input logic [4:0] rd);
    return (rd == x) && (rd != 5'd0);
  endfunction

  function automatic logic [WIDTH-1:0] fwd(
    input logic [4:0]       src,
    input logic [WIDTH-1:0] rf_val,
    input logic             m_rw,
    input logic             m_rd_load,
    input logic [4:0]       m_rd,
    input logic [WIDTH-1:0] m_alu,
    input logic             w_rw,
    input logic [4:0]       w_rd,
    input logic [WIDTH-1:0] w_data
  );
    if (m_rw && !m_rd_load && hit(src, m_rd)) begin
      return m_alu;
    end else if (w_rw && hit(src, w_rd)) begin
      return w_data;
    end else begin
      return rf_val;
    end
  endfunction

  assign bus.cmp_a = fwd(bus.id_rs, bus.rf_rs, bus.mem_regwrite, bus.mem_memread, bus.mem_rd,
                         bus.mem_alu, bus.wb_regwrite, bus.wb_rd, bus.wb_data);
  assign bus.cmp_b = fwd(bus.id_rt, bus.rf_rt, bus.mem_regwrite, bus.mem_memread, bus.mem_rd,
                         bus.mem_alu, bus.wb_regwrite, bus.wb_rd, bus.wb_data);

  assign ex_hit_s   = hit(bus.id_rs, bus.ex_rd) | hit(bus.id_rt, bus.ex_rd);
  assign mem_hit_s  = hit(bus.id_rs, bus.mem_rd) | hit(bus.id_rt, bus.mem_rd);
  assign need_two_s = bus.ex_regwrite & bus.ex_memread & ex_hit_s;
  assign need_one_s = (bus.ex_regwrite & ~bus.ex_memread & ex_hit_s) | (bus.mem_memread & mem_hit_s);

  // Next-state, stall and resolve decode; hazards are only evaluated from IDLE.
  always_comb begin
    state_d   = state_q;
    stall_s   = 1'b0;
    resolve_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.id_branch) begin
          state_d = IDLE;
        end else if (need_two_s) begin
          stall_s = 1'b1;
          state_d = STALL;
        end else if (need_one_s) begin
          stall_s = 1'b1;
          state_d = RESOLVE;
        end else begin
          resolve_s = 1'b1;
        end
      end
      STALL: begin
        if (bus.id_branch) begin
          stall_s = 1'b1;
          state_d = RESOLVE;
        end else begin
          state_d = IDLE;
        end
      end
      RESOLVE: begin
        state_d   = IDLE;
        resolve_s = bus.id_branch;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign taken_s = resolve_s & (bus.cmp_eq ^ bus.id_bne);

  // Saturating statistics; a clear overrides any increment in the same cycle.
  always_comb begin
    branch_cnt_d = branch_cnt_q;
    taken_cnt_d  = taken_cnt_q;
    if (bus.cnt_clr) begin
      branch_cnt_d = {CNT_W{1'b0}};
      taken_cnt_d  = {CNT_W{1'b0}};
    end else begin
      if (resolve_s && !(&branch_cnt_q)) begin
        branch_cnt_d = branch_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        branch_cnt_d = branch_cnt_q;
      end
      if (taken_s && !(&taken_cnt_q)) begin
        taken_cnt_d = taken_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        taken_cnt_d = taken_cnt_q;
      end
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      branch_cnt_q <= {CNT_W{1'b0}};
      taken_cnt_q  <= {CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      branch_cnt_q <= branch_cnt_d;
      taken_cnt_q  <= taken_cnt_d;
    end
  end

  // Control outputs are forced low while reset is held, even mid-stall.
  assign bus.stall        = stall_s & ~reset;
  assign bus.branch_taken = taken_s & ~reset;
  assign bus.flush_ifid   = taken_s & ~reset;
  assign bus.branch_cnt   = branch_cnt_q;
  assign bus.taken_cnt    = taken_cnt_q;

endmodule

// File: tb/tb_branch_cmp_ctrl.sv
// Directed bench for branch_cmp_ctrl: expected values are queued as each step
// is driven and popped when the corresponding DUT output is sampled.
module tb_branch_cmp_ctrl;
  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [31:0] exp_q[$];

  branch_cmp_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  branch_cmp_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // External equality comparator fed by the controller's operand mux.
  assign bus.cmp_eq = (bus.cmp_a == bus.cmp_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_v(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s observed=%0h expected=<empty scoreboard>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_pipe();
    bus.ex_regwrite  = 1'b0; bus.ex_memread  = 1'b0; bus.ex_rd  = 5'd0;
    bus.mem_regwrite = 1'b0; bus.mem_memread = 1'b0; bus.mem_rd = 5'd0;
    bus.mem_alu      = 32'd0;
    bus.wb_regwrite  = 1'b0; bus.wb_rd = 5'd0; bus.wb_data = 32'd0;
  endtask

  task automatic set_branch(input logic br, input logic bne, input logic [4:0] rs,
                            input logic [4:0] rt, input logic [31:0] a, input logic [31:0] b);
    bus.id_branch = br; bus.id_bne = bne; bus.id_rs = rs; bus.id_rt = rt;
    bus.rf_rs = a; bus.rf_rt = b;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.cnt_clr = 1'b0;
    clear_pipe();
    // Reset: a hazard-laden branch still yields no stall or taken.
    set_branch(1'b1, 1'b0, 5'd5, 5'd5, 32'd1, 32'd1);
    bus.ex_regwrite = 1'b1; bus.ex_memread = 1'b1; bus.ex_rd = 5'd5;
    tick(); tick();
    expect_v(32'd0); chk("rst_stall", bus.stall);
    expect_v(32'd0); chk("rst_taken", bus.branch_taken);
    expect_v(32'd0); chk("rst_bcnt", bus.branch_cnt);
    clear_pipe();
    set_branch(1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // 1: BEQ with no hazard resolves in the same cycle.
    set_branch(1'b1, 1'b0, 5'd3, 5'd3, 32'd25, 32'd25);
    settle();
    expect_v(32'd1); chk("t1_taken", bus.branch_taken);
    expect_v(32'd1); chk("t1_flush", bus.flush_ifid);
    expect_v(32'd0); chk("t1_stall", bus.stall);
    tick();
    bus.id_branch = 1'b0;
    settle();
    expect_v(32'd1); chk("t1_bcnt", bus.branch_cnt);
    expect_v(32'd1); chk("t1_tcnt", bus.taken_cnt);

    // 2: load in EX feeding BNE rs -> two stalls, then forwarded from WB.
    set_branch(1'b1, 1'b1, 5'd5, 5'd6, 32'd99, 32'd25);
    bus.ex_regwrite = 1'b1; bus.ex_memread = 1'b1; bus.ex_rd = 5'd5;
    settle();
    expect_v(32'd1); chk("t2_stall0", bus.stall);
    expect_v(32'd0); chk("t2_taken0", bus.branch_taken);
    tick();
    clear_pipe();
    bus.mem_regwrite = 1'b1; bus.mem_memread = 1'b1; bus.mem_rd = 5'd5;
    settle();
    expect_v(32'd1); chk("t2_stall1", bus.stall);
    expect_v(32'd0); chk("t2_taken1", bus.branch_taken);
    tick();
    clear_pipe();
    bus.wb_regwrite = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'd10;
    settle();
    expect_v(32'd0);  chk("t2_stall2", bus.stall);
    expect_v(32'd10); chk("t2_cmp_a", bus.cmp_a);
    expect_v(32'd1);  chk("t2_taken2", bus.branch_taken);
    tick();
    bus.id_branch = 1'b0; clear_pipe();
    settle();
    expect_v(32'd2); chk("t2_bcnt", bus.branch_cnt);

    // 3: ALU result in EX -> one stall, then MEM beats WB for $7.
    set_branch(1'b1, 1'b0, 5'd2, 5'd7, 32'd40, 32'd0);
    bus.ex_regwrite = 1'b1; bus.ex_memread = 1'b0; bus.ex_rd = 5'd7;
    settle();
    expect_v(32'd1); chk("t3_stall0", bus.stall);
    tick();
    clear_pipe();
    bus.mem_regwrite = 1'b1; bus.mem_rd = 5'd7; bus.mem_alu = 32'd40;
    bus.wb_regwrite  = 1'b1; bus.wb_rd  = 5'd7; bus.wb_data = 32'd55;
    settle();
    expect_v(32'd0);  chk("t3_stall1", bus.stall);
    expect_v(32'd40); chk("t3_cmp_b", bus.cmp_b);
    expect_v(32'd1);  chk("t3_taken", bus.branch_taken);
    tick();
    clear_pipe();

    // WB-only forward, no stall.
    set_branch(1'b1, 1'b0, 5'd8, 5'd9, 32'd1, 32'd77);
    bus.wb_regwrite = 1'b1; bus.wb_rd = 5'd8; bus.wb_data = 32'd77;
    settle();
    expect_v(32'd77); chk("wb_cmp_a", bus.cmp_a);
    expect_v(32'd1);  chk("wb_taken", bus.branch_taken);
    tick();
    clear_pipe();

    // 4: register 0 neither stalls nor forwards.
    set_branch(1'b1, 1'b1, 5'd0, 5'd0, 32'h123, 32'h456);
    bus.ex_regwrite  = 1'b1; bus.ex_memread = 1'b1; bus.ex_rd = 5'd0;
    bus.mem_regwrite = 1'b1; bus.mem_rd = 5'd0; bus.mem_alu = 32'd999;
    settle();
    expect_v(32'd0);     chk("t4_stall", bus.stall);
    expect_v(32'h123);   chk("t4_cmp_a", bus.cmp_a);
    expect_v(32'd1);     chk("t4_taken", bus.branch_taken);
    tick();
    bus.id_branch = 1'b0; clear_pipe();
    settle();
    expect_v(32'd5); chk("t4_bcnt", bus.branch_cnt);
    expect_v(32'd5); chk("t4_tcnt", bus.taken_cnt);

    // 5a: reset while in STALL.
    set_branch(1'b1, 1'b0, 5'd5, 5'd5, 32'd3, 32'd3);
    bus.ex_regwrite = 1'b1; bus.ex_memread = 1'b1; bus.ex_rd = 5'd5;
    tick();
    clear_pipe();
    settle();
    expect_v(32'd1); chk("t5_stall_in", bus.stall);
    reset = 1'b1;
    settle();
    expect_v(32'd0); chk("t5_stall_rst", bus.stall);
    expect_v(32'd0); chk("t5_bcnt_rst", bus.branch_cnt);
    tick();
    reset = 1'b0;
    bus.id_branch = 1'b0;
    tick();

    // 5b: branch withdrawn while in RESOLVE.
    set_branch(1'b1, 1'b0, 5'd7, 5'd4, 32'd6, 32'd6);
    bus.ex_regwrite = 1'b1; bus.ex_rd = 5'd7;
    settle();
    expect_v(32'd1); chk("t5_stall1", bus.stall);
    tick();
    clear_pipe();
    bus.id_branch = 1'b0;
    settle();
    expect_v(32'd0); chk("t5_abort_taken", bus.branch_taken);
    tick();
    expect_v(32'd0); chk("t5_abort_bcnt", bus.branch_cnt);
    set_branch(1'b1, 1'b0, 5'd1, 5'd2, 32'd8, 32'd8);
    settle();
    expect_v(32'd1); chk("t5_idle_taken", bus.branch_taken);
    expect_v(32'd0); chk("t5_idle_stall", bus.stall);
    tick();
    expect_v(32'd1); chk("t5_idle_bcnt", bus.branch_cnt);

    // 6: saturation, then clear racing an increment.
    for (int i = 0; i < 20; i++) tick();
    expect_v(32'd15); chk("t6_bcnt_sat", bus.branch_cnt);
    expect_v(32'd15); chk("t6_tcnt_sat", bus.taken_cnt);
    bus.id_bne = 1'b1;
    tick();
    expect_v(32'd15); chk("t6_bcnt_hold", bus.branch_cnt);
    bus.id_bne = 1'b0;
    bus.cnt_clr = 1'b1;
    settle();
    expect_v(32'd1); chk("t6_clr_taken", bus.branch_taken);
    tick();
    bus.cnt_clr = 1'b0;
    expect_v(32'd0); chk("t6_clr_bcnt", bus.branch_cnt);
    expect_v(32'd0); chk("t6_clr_tcnt", bus.taken_cnt);
    tick();
    bus.id_branch = 1'b0;
    expect_v(32'd1); chk("t6_after_clr", bus.branch_cnt);

    if (exp_q.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
